weight_bank_loader: RTL

//  Parametrised multi-channel weight store with its own loader FSM. Owns N_CH x DEPTH words.

---
 rtl/weight_pkg.sv | 14 +
 rtl/weight_lfsr.sv | 27 ++
 rtl/weight_bank_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/weight_pkg.sv
// Shared types and constants for the weight bank loader: FSM states and the LFSR seed/tap mask.
package weight_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RAND, DONE} wload_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps x^16+x^14+x^13+x^11+1 for the right-shifting Galois form
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/weight_lfsr.sv
// 16-bit Galois LFSR used to fill the weight bank with pseudo-random words.
// Reseeds on reset or Seed_load; steps once per cycle with Advance.
module weight_lfsr
  import weight_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             Seed_load,
  input  logic             Advance,
  output logic [OUT_W-1:0] Value
);

  logic [15:0] value_reg;

  always_ff @(posedge Clock) begin
    if (!Rst || Seed_load) begin
      value_reg <= LFSR_SEED;
    end else if (Advance) begin
      value_reg <= lfsr_next(value_reg);
    end
  end

  assign Value = value_reg[OUT_W-1:0];

endmodule

// File: rtl/weight_bank_loader.sv
// Multi-channel weight store with streamed or LFSR fill and a shared registered read port.
// Optional running checksum of written words is built when WEIGHT_CHECKSUM_EN is defined.
module weight_bank_loader
  import weight_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 128,
  parameter int N_CH  = 10,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  Start_load,
  input  logic                  Start_rand,
  input  logic                  Abort,
  input  logic                  In_valid,
  input  logic [WIDTH-1:0]      In_data,
  output logic                  In_ready,
  input  logic [AW-1:0]         Rd_addr,
  output logic [N_CH*WIDTH-1:0] Q,
  output logic                  Busy,
  output logic                  Done,
  output logic [AW-1:0]         Wr_addr,
  output logic [15:0]           Checksum
);

  wload_state_t     state_reg, state_next;
  logic [AW-1:0]    addr_reg;
  logic [CW-1:0]    ch_reg;
  logic [WIDTH-1:0] lfsr_word;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             last_word;
  logic             entering;

  // Only reset reseeds, so back-to-back random fills continue the sequence
  weight_lfsr #(.OUT_W(WIDTH)) u_lfsr (
    .Clock    (Clock),
    .Rst      (Rst),
    .Seed_load(1'b0),
    .Advance  (state_reg == RAND),
    .Value    (lfsr_word)
  );

  assign wr_en     = (state_reg == RAND) || ((state_reg == LOAD) && In_valid);
  assign wr_data   = (state_reg == RAND) ? lfsr_word : In_data;
  assign last_word = wr_en && (addr_reg == AW'(DEPTH - 1)) && (ch_reg == CW'(N_CH - 1));
  assign entering  = (state_reg == IDLE) && (Start_load || Start_rand);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (Start_load)      state_next = LOAD;
        else if (Start_rand) state_next = RAND;
      end
      LOAD, RAND: begin
        // Abort wins over completion so an aborted final write raises no Done
        if (Abort)          state_next = IDLE;
        else if (last_word) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (entering) begin
        addr_reg <= '0;
        ch_reg   <= '0;
      end else if (wr_en) begin
        if (ch_reg == CW'(N_CH - 1)) begin
          ch_reg   <= '0;
          addr_reg <= (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + AW'(1);
        end else begin
          ch_reg <= ch_reg + CW'(1);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge Clock) begin
        if (wr_en && (ch_reg == CW'(gi))) begin
          mem[addr_reg] <= wr_data;
        end
      end

      // Read register samples the pre-write contents on a same-address collision
      always_ff @(posedge Clock) begin
        if (!Rst) q_reg <= '0;
        else      q_reg <= mem[Rd_addr];
      end

      assign Q[gi*WIDTH +: WIDTH] = q_reg;
    end
  endgenerate

`ifdef WEIGHT_CHECKSUM_EN
  logic [15:0] csum_reg;

  always_ff @(posedge Clock) begin
    if (!Rst || entering) begin
      csum_reg <= '0;
    end else if (wr_en) begin
      csum_reg <= csum_reg + 16'(wr_data);
    end
  end

  assign Checksum = csum_reg;
`else
  assign Checksum = 16'h0000;
`endif

  assign In_ready = (state_reg == LOAD);
  assign Busy     = (state_reg == LOAD) || (state_reg == RAND);
  assign Done     = (state_reg == DONE);
  assign Wr_addr  = addr_reg;

endmodule
